// File: rtl/sdram_burst_sched_if.sv
// Handshake bundle between the burst scheduler (master) and the SDRAM controller (slave).
interface sdram_burst_sched_if #(
    parameter int unsigned ADDR_W = 22
) ();
    logic              sdram_init_done;
    logic              sdram_busy;
    logic              sdram_wr_ack;
    logic              sdram_rd_ack;
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic [8:0]        sdwr_byte;
    logic [8:0]        sdrd_byte;
    logic [ADDR_W-1:0] sys_addr;

    modport master (
        input  sdram_init_done, sdram_busy, sdram_wr_ack, sdram_rd_ack,
        output sdram_wr_req, sdram_rd_req, sdwr_byte, sdrd_byte, sys_addr
    );

    modport slave (
        output sdram_init_done, sdram_busy, sdram_wr_ack, sdram_rd_ack,
        input  sdram_wr_req, sdram_rd_req, sdwr_byte, sdrd_byte, sys_addr
    );
endinterface

// File: rtl/sdram_burst_sched.sv
// Burst scheduler: issues full-length SDRAM write/read bursts from FIFO fill levels and
// manages the SDRAM region as a circular buffer of burst slots.
module sdram_burst_sched #(
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned FIFO_AW   = 9,
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned SLOTS     = 16384
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FIFO_AW:0]    wfifo_usedw,
    input  logic [FIFO_AW:0]    rfifo_usedw,
    input  logic                addr_clr,
    sdram_burst_sched_if.master ctrl,
    output logic [ADDR_W:0]     occupancy,
    output logic                ack_err
);
    localparam int unsigned PtrW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [FIFO_AW:0] BurstLenF = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] FifoDepth = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [ADDR_W:0]  SlotsU    = (ADDR_W+1)'(SLOTS);
    localparam logic [PtrW-1:0]  LastSlot  = PtrW'(SLOTS - 1);
    localparam logic [8:0]       BeatFull  = 9'(BURST_LEN);

    typedef enum logic [2:0] {
        StIdle, StWrReq, StWrRun, StWrDone, StRdReq, StRdRun, StRdDone
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, ptr_sel;
    logic [ADDR_W:0]   occ_q;
    logic              last_wr_q, clr_pend_q, ack_err_q;
    logic [8:0]        beat_q;
    logic              wr_req_q, rd_req_q, wr_req_d, rd_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              can_check, wr_ok, rd_ok, clr_now;

    // A clear arriving in IDLE also blocks issue so pointers never move under a new burst.
    assign can_check = ctrl.sdram_init_done && !clr_pend_q && !addr_clr;
    assign wr_ok     = can_check && (wfifo_usedw >= BurstLenF) && (occ_q < SlotsU);
    assign rd_ok     = can_check && (occ_q != '0) && ((FifoDepth - rfifo_usedw) >= BurstLenF);
    assign clr_now   = (state_q == StIdle) && (addr_clr || clr_pend_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (wr_ok && (!rd_ok || !last_wr_q)) begin
                    state_d = StWrReq;
                end else if (rd_ok) begin
                    state_d = StRdReq;
                end
            end
            StWrReq:  if (ctrl.sdram_wr_ack) state_d = StWrRun;
            StWrRun:  if (!ctrl.sdram_busy) state_d = StWrDone;
            StWrDone: state_d = StIdle;
            StRdReq:  if (ctrl.sdram_rd_ack) state_d = StRdRun;
            StRdRun:  if (!ctrl.sdram_busy) state_d = StRdDone;
            StRdDone: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state and registered, so they change on the edge.
    always_comb begin
        wr_req_d = (state_d == StWrReq);
        rd_req_d = (state_d == StRdReq);
        case (state_d)
            StWrReq, StWrRun, StWrDone: ptr_sel = wr_ptr_q;
            StRdReq, StRdRun, StRdDone: ptr_sel = rd_ptr_q;
            default:                    ptr_sel = last_wr_q ? rd_ptr_q : wr_ptr_q;
        endcase
        addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(ptr_sel) * ADDR_W'(BURST_LEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            last_wr_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            ack_err_q  <= 1'b0;
            beat_q     <= '0;
        end else begin
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            addr_q   <= addr_d;

            if (addr_clr && (state_q != StIdle)) begin
                clr_pend_q <= 1'b1;
            end

            if ((state_q == StIdle) && (state_d != StIdle)) begin
                beat_q <= '0;
            end else if ((((state_q == StWrReq) || (state_q == StWrRun)) && ctrl.sdram_wr_ack) ||
                         (((state_q == StRdReq) || (state_q == StRdRun)) && ctrl.sdram_rd_ack)) begin
                beat_q <= beat_q + 9'd1;
            end

            case (state_q)
                StWrDone: begin
                    wr_ptr_q  <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + PtrW'(1);
                    occ_q     <= occ_q + (ADDR_W+1)'(1);
                    last_wr_q <= 1'b1;
                    if (beat_q != BeatFull) ack_err_q <= 1'b1;
                end
                StRdDone: begin
                    rd_ptr_q  <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + PtrW'(1);
                    occ_q     <= occ_q - (ADDR_W+1)'(1);
                    last_wr_q <= 1'b0;
                    if (beat_q != BeatFull) ack_err_q <= 1'b1;
                end
                StIdle: begin
                    if (clr_now) begin
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        occ_q      <= '0;
                        ack_err_q  <= 1'b0;
                        clr_pend_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctrl.sdram_wr_req = wr_req_q;
    assign ctrl.sdram_rd_req = rd_req_q;
    assign ctrl.sys_addr     = addr_q;
    assign ctrl.sdwr_byte    = 9'(BURST_LEN);
    assign ctrl.sdrd_byte    = 9'(BURST_LEN);
    assign occupancy         = occ_q;
    assign ack_err           = ack_err_q;
endmodule

// File: tb/tb_sdram_burst_sched.sv
// Randomized bench for sdram_burst_sched against a slot-level circular-buffer model.
module tb_sdram_burst_sched;
    localparam int unsigned BL    = 256;
    localparam int unsigned FAW   = 9;
    localparam int unsigned AW    = 22;
    localparam int unsigned BASE  = 0;
    localparam int unsigned SLOTS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FAW:0]  wf, rf;
    logic          addr_clr;
    logic [AW:0]   occ;
    logic          ack_err;

    sdram_burst_sched_if #(.ADDR_W(AW)) bus ();

    sdram_burst_sched #(
        .BURST_LEN(BL), .FIFO_AW(FAW), .ADDR_W(AW), .BASE_ADDR(BASE), .SLOTS(SLOTS)
    ) dut (
        .clk(clk), .rst(rst), .wfifo_usedw(wf), .rfifo_usedw(rf), .addr_clr(addr_clr),
        .ctrl(bus.master), .occupancy(occ), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: slot indices, occupancy, round-robin flag, sticky error.
    int m_occ = 0, m_wr = 0, m_rd = 0;
    bit m_last_wr = 1'b0, m_ack_err = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int reqs();
        return int'({bus.sdram_wr_req, bus.sdram_rd_req});
    endfunction

    task automatic set_idle_levels();
        wf = '0;
        rf = (FAW+1)'(1 << FAW);
    endtask

    task automatic model_clear();
        m_occ = 0; m_wr = 0; m_rd = 0; m_ack_err = 1'b0;
    endtask

    // Entered on the negedge where the request was first seen high.
    task automatic run_burst(input bit is_wr, input int nacks, input int refresh, input bit clr_mid);
        int exp_addr;
        exp_addr = int'(BASE + (is_wr ? m_wr : m_rd) * BL);
        if (clr_mid) begin
            wf = (FAW+1)'(300);
            rf = (FAW+1)'(1 << FAW);
        end else begin
            set_idle_levels();
        end
        bus.sdram_busy = 1'b1;
        repeat (refresh) @(negedge clk);
        if (refresh > 0) check_eq("req_hold_refresh", reqs(), is_wr ? 2 : 1);
        for (int i = 0; i < nacks; i++) begin
            if (is_wr) bus.sdram_wr_ack = 1'b1; else bus.sdram_rd_ack = 1'b1;
            addr_clr = (clr_mid && i == nacks / 2);
            @(negedge clk);
            if (i == 0) check_eq("req_fall", reqs(), 0);
        end
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_rd_ack = 1'b0;
        addr_clr = 1'b0;
        check_eq("addr_stable", int'(bus.sys_addr), exp_addr);
        bus.sdram_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (is_wr) begin
            m_wr = (m_wr + 1) % SLOTS; m_occ++; m_last_wr = 1'b1;
        end else begin
            m_rd = (m_rd + 1) % SLOTS; m_occ--; m_last_wr = 1'b0;
        end
        if (nacks != BL) m_ack_err = 1'b1;
        check_eq("occ_done", int'(occ), m_occ);
        check_eq("ack_err_done", int'(ack_err), int'(m_ack_err));
        if (clr_mid) begin
            // Write is eligible here, but the pending clear must win first.
            @(negedge clk);
            model_clear();
            check_eq("clr_no_req", reqs(), 0);
            check_eq("clr_occ", int'(occ), 0);
            check_eq("clr_ack_err", int'(ack_err), 0);
            set_idle_levels();
        end
    endtask

    task automatic issue(input int w, input int r, input bit init, input int nacks,
                         input int refresh, input bit clr_mid);
        bit wok, rok;
        check_eq("idle_before", reqs(), 0);
        wf = (FAW+1)'(w);
        rf = (FAW+1)'(r);
        bus.sdram_init_done = init;
        wok = init && (w >= BL) && (m_occ < SLOTS);
        rok = init && (m_occ >= 1) && (((1 << FAW) - r) >= BL);
        @(negedge clk);
        if (wok && (!rok || !m_last_wr)) begin
            check_eq("wr_rise", reqs(), 2);
            check_eq("wr_addr", int'(bus.sys_addr), int'(BASE + m_wr * BL));
            run_burst(1'b1, nacks, refresh, clr_mid);
        end else if (rok) begin
            check_eq("rd_rise", reqs(), 1);
            check_eq("rd_addr", int'(bus.sys_addr), int'(BASE + m_rd * BL));
            run_burst(1'b0, nacks, refresh, clr_mid);
        end else begin
            repeat (4) @(negedge clk);
            check_eq("no_req", reqs(), 0);
            check_eq("occ_hold", int'(occ), m_occ);
            set_idle_levels();
        end
        bus.sdram_init_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic clr_idle();
        addr_clr = 1'b1;
        @(negedge clk);
        addr_clr = 1'b0;
        model_clear();
        check_eq("clr_idle_occ", int'(occ), 0);
        check_eq("clr_idle_err", int'(ack_err), 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, r, na;
        rst = 1'b1;
        addr_clr = 1'b0;
        set_idle_levels();
        bus.sdram_init_done = 1'b1;
        bus.sdram_busy = 1'b0;
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req", reqs(), 0);
        check_eq("rst_addr", int'(bus.sys_addr), int'(BASE));
        check_eq("rst_occ", int'(occ), 0);
        check_eq("rst_err", int'(ack_err), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("wr_len", int'(bus.sdwr_byte), BL);
        check_eq("rd_len", int'(bus.sdrd_byte), BL);

        // Write path, then round-robin alternation.
        issue(256, 0, 1'b1, BL, 0, 1'b0);
        for (int i = 0; i < 3; i++) issue(300, 0, 1'b1, BL, 0, 1'b0);
        // Fill to SLOTS, then confirm writes stall; drain, then confirm reads stall.
        for (int i = 0; i < SLOTS + 1; i++) issue(511, 512, 1'b1, BL, 0, 1'b0);
        for (int i = 0; i < SLOTS + 1; i++) issue(0, 0, 1'b1, BL, 0, 1'b0);
        // Refresh before the first ack, short read burst, sticky error, clears.
        issue(256, 512, 1'b1, BL, 10, 1'b0);
        issue(0, 0, 1'b1, BL - 1, 0, 1'b0);
        issue(0, 512, 1'b1, BL, 0, 1'b0);
        check_eq("err_sticky", int'(ack_err), 1);
        clr_idle();
        issue(256, 512, 1'b1, BL, 0, 1'b0);
        issue(256, 512, 1'b1, BL, 0, 1'b0);
        issue(0, 0, 1'b1, BL, 0, 1'b1);
        issue(256, 512, 1'b1, BL, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            w  = ($urandom_range(0, 1) != 0) ? $urandom_range(256, 511) : $urandom_range(0, 255);
            r  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 256) : $urandom_range(257, 512);
            na = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? BL - 1 : BL + 1) : BL;
            if ($urandom_range(0, 9) == 0) clr_idle();
            issue(w, r, ($urandom_range(0, 7) != 0), na, $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
